sar_ramp_search: RTL
====================

# sar_ramp_search

Conversion engine for the discrete comparator ADCs (R2R ladder and filtered-PWM DAC). It drives a trial DAC code and reads back the external comparator. A conversion is triggered by an internal sample-rate tick. The search runs as either successive approximation or linear ramp. Each finished code is presented as a left-justified 16-bit word with a one-cycle `data_ready` pulse. The output feeds the `adc_processing` averaging/scaling stage directly.

## Interface
- `WIDTH`, 8, DAC/result bit width (2..16)
- `CLOCK_FREQ`, 100_000_000, clock frequency in Hz
- `SAMPLING_FREQ`, 2000, conversion start rate in Hz; N = CLOCK_FREQ/SAMPLING_FREQ
- `SETTLE_CYCLES`, 64, DAC settling cycles before each comparator decision (≥2)
- `clk`, in, 1, sole clock
- `reset`, in, 1, synchronous, active-low
- `en`, in, 1, engine enable from the menu subsystem
- `sa_en`, in, 1, 1 = successive approximation, 0 = ramp
- `comparator`, in, 1, async; 1 = Vin ≥ Vdac
- `dac_code`, out, WIDTH, trial code to the DAC/PWM generator
- `data_ready`, out, 1, one-cycle result-valid pulse
- `adc_out`, out, 16, result left-justified: {result, (16-WIDTH) zeros}

## Operation
- Reset (reset=0 at a clk edge): state IDLE, tick counter 0, `dac_code`=0, `data_ready`=0, `adc_out`=0.
- States: IDLE, WAIT_TICK, SETTLE, DECIDE, DONE.
- IDLE → WAIT_TICK when `en`=1.
- `en`=0 in any state → IDLE next cycle. In that case `dac_code`=0, the tick counter clears, no `data_ready` is issued, and `adc_out` holds its value.
- The tick counter counts 0..N-1 while `en`=1. The tick is asserted for one cycle at N-1.
- WAIT_TICK on tick:
  - Latch `sa_en` into the mode register. A mid-conversion `sa_en` change takes effect at the next conversion.
  - Load the first code: SAR uses 1<<(WIDTH-1); ramp uses 0.
  - Clear the settle counter and go to SETTLE.
- Ticks arriving outside WAIT_TICK are ignored.
- SETTLE lasts exactly SETTLE_CYCLES cycles, then goes to DECIDE. DECIDE lasts one cycle and samples the comparator (`comp_s`).
- SAR, bit index i from WIDTH-1 down to 0:
  - `comp_s`=0 → clear bit i.
  - If i=0 → DONE.
  - Otherwise set bit i-1, decrement i, and return to SETTLE.
- Ramp:
  - `comp_s`=0 → result = code-1, clamped to 0 when code=0; go to DONE.
  - `comp_s`=1 and code=2^WIDTH-1 → result = 2^WIDTH-1; go to DONE.
  - Otherwise code+1 and return to SETTLE.
- DONE (one cycle):
  - `adc_out` ← {result, zeros}.
  - `data_ready`=1.
  - `dac_code` ← result, held until the next conversion loads.
  - Next state WAIT_TICK.
- Elaboration check: the worst-case ramp time 2^WIDTH·(SETTLE_CYCLES+1)+1 must be < N. Otherwise, `$fatal`.

## Timing
- Tick at cycle T → first trial code visible at T+1.
- SAR: `data_ready` at T + WIDTH·(SETTLE_CYCLES+1) + 1.
- Ramp, result k < max: `data_ready` at T + (k+2)·(SETTLE_CYCLES+1) + 1.
- Ramp, result max: `data_ready` at T + 2^WIDTH·(SETTLE_CYCLES+1) + 1.
- `adc_out` changes only in the same cycle `data_ready` is high. It is stable for at least N−latency cycles afterwards.
- `data_ready` and all outputs are registered.
- Reset or `en` fall during SETTLE/DECIDE: the conversion is discarded with no pulse.

## Configuration
- `COMP_SYNC_EN` defined:
  - `comparator` passes through a 2-flop synchronizer before `comp_s`.
  - The 2-cycle delay is absorbed in SETTLE (SETTLE_CYCLES ≥ 2 enforced), so cycle counts are unchanged.
- Not defined:
  - `comp_s` is a single register of `comparator`.
  - SETTLE_CYCLES ≥ 1 is sufficient.

## Structure
- Shared `adc_pkg`:
  - `search_state_t` enum (IDLE, WAIT_TICK, SETTLE, DECIDE, DONE).
  - `search_mode_t` enum (MODE_RAMP, MODE_SAR).
  - `ADC_OUT_W` = 16.
- One sub-module, `sample_tick_gen`:
  - Parameters CLOCK_FREQ and SAMPLING_FREQ.
  - Ports `clk`, `reset`, `en`, `tick`.
  - Also reused by other sampled blocks.

## Test plan
All scenarios use the bench parameters CLOCK_FREQ=200_000, SAMPLING_FREQ=100 (N=2000), SETTLE_CYCLES=4, WIDTH=8. The comparator model is `comparator` = (vin ≥ `dac_code`).
- SAR, vin=0x9C, `sa_en`=1 → `data_ready` 41 cycles after tick, `adc_out`=0x9C00, `dac_code`=0x9C.
- Ramp, vin=0x9C, `sa_en`=0 → `data_ready` 791 cycles after tick, `adc_out`=0x9C00.
- Boundaries:
  - vin=0x00 in either mode → `adc_out`=0x0000.
  - vin=0xFF (comparator stuck 1) → SAR gives 0xFF00; ramp gives 0xFF00 after 1281 cycles.
- Drop `en` to 0 mid-SAR → no `data_ready`, `dac_code`=0 next cycle, `adc_out` keeps the previous value. Re-enable → first tick after a full N count.
- Assert reset (0) mid-ramp → next cycle all outputs 0, state IDLE. A `sa_en` toggle mid-conversion → the current conversion keeps its latched mode.
- Cycle-accurate latency checks, run with `COMP_SYNC_EN` defined and undefined:
  - `data_ready` pulses exactly one cycle per conversion.
  - Consecutive pulses are spaced exactly N cycles apart.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the comparator-ADC conversion path.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    SETTLE,
    DECIDE,
    DONE
  } search_state_t;

  typedef enum logic {
    MODE_RAMP,
    MODE_SAR
  } search_mode_t;

  localparam int ADC_OUT_W = 16;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: a one-cycle tick every CLOCK_FREQ/SAMPLING_FREQ
// clocks while enabled; the count restarts from zero whenever en drops.
module sample_tick_gen #(
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int SAMPLING_FREQ = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int N  = CLOCK_FREQ / SAMPLING_FREQ;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < 2) begin : g_bad_ratio
    $fatal(1, "sample_tick_gen: CLOCK_FREQ/SAMPLING_FREQ must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || !en) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // Combinational so the search loads its first trial code on the cycle after the tick.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/sar_ramp_search.sv
// Comparator-ADC search engine (successive approximation or linear ramp).
// Optional build macro COMP_SYNC_EN: 2-flop comparator synchronizer, delay hidden inside SETTLE.
module sar_ramp_search
  import adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int SAMPLING_FREQ = 2000,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sa_en,
  input  logic                 comparator,
  output logic [WIDTH-1:0]     dac_code,
  output logic                 data_ready,
  output logic [ADC_OUT_W-1:0] adc_out
);

  localparam int     N          = CLOCK_FREQ / SAMPLING_FREQ;
  localparam int     IW         = $clog2(WIDTH);
  localparam int     SW         = $clog2(SETTLE_CYCLES + 1);
  localparam longint RAMP_WORST = (longint'(1) << WIDTH) * longint'(SETTLE_CYCLES + 1) + 1;

  localparam logic [WIDTH-1:0] SAR_FIRST   = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_MAX    = {WIDTH{1'b1}};
  localparam logic [IW-1:0]    IDX_TOP     = IW'(WIDTH - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

`ifdef COMP_SYNC_EN
  localparam int SETTLE_MIN = 2;
`else
  localparam int SETTLE_MIN = 1;
`endif

  if (WIDTH < 2 || WIDTH > ADC_OUT_W) begin : g_bad_width
    $fatal(1, "sar_ramp_search: WIDTH must be in 2..16");
  end
  if (SETTLE_CYCLES < SETTLE_MIN) begin : g_bad_settle
    $fatal(1, "sar_ramp_search: SETTLE_CYCLES too small for comparator path");
  end
  if (RAMP_WORST >= longint'(N)) begin : g_bad_rate
    $fatal(1, "sar_ramp_search: worst-case ramp does not fit in one sample period");
  end

  logic tick;

  sample_tick_gen #(
    .CLOCK_FREQ    (CLOCK_FREQ),
    .SAMPLING_FREQ (SAMPLING_FREQ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  logic comp_s;

`ifdef COMP_SYNC_EN
  logic comp_meta;
  always_ff @(posedge clk) begin
    if (!reset) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comparator;
      comp_s    <= comp_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) comp_s <= 1'b0;
    else        comp_s <= comparator;
  end
`endif

  search_state_t        state, state_nxt;
  search_mode_t         mode, mode_nxt;
  logic [IW-1:0]        bit_idx, idx_nxt;
  logic [SW-1:0]        settle_cnt, settle_nxt;
  logic [WIDTH-1:0]     code_nxt, trial, res;
  logic                 ready_nxt, fin;
  logic [ADC_OUT_W-1:0] adc_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mode       <= MODE_RAMP;
      bit_idx    <= '0;
      settle_cnt <= '0;
      dac_code   <= '0;
      data_ready <= 1'b0;
      adc_out    <= '0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      bit_idx    <= idx_nxt;
      settle_cnt <= settle_nxt;
      dac_code   <= code_nxt;
      data_ready <= ready_nxt;
      adc_out    <= adc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode;
    idx_nxt    = bit_idx;
    settle_nxt = settle_cnt;
    code_nxt   = dac_code;
    ready_nxt  = 1'b0;
    adc_nxt    = adc_out;
    trial      = dac_code;
    res        = '0;
    fin        = 1'b0;

    if (!en) begin
      // Abandon any conversion silently; adc_out keeps the last good result.
      state_nxt  = IDLE;
      code_nxt   = '0;
      settle_nxt = '0;
    end else begin
      unique case (state)
        IDLE: state_nxt = WAIT_TICK;

        WAIT_TICK: begin
          if (tick) begin
            mode_nxt   = sa_en ? MODE_SAR : MODE_RAMP;
            code_nxt   = sa_en ? SAR_FIRST : '0;
            idx_nxt    = IDX_TOP;
            settle_nxt = '0;
            state_nxt  = SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state_nxt = DECIDE;
          else                           settle_nxt = settle_cnt + 1'b1;
        end

        DECIDE: begin
          settle_nxt = '0;
          if (mode == MODE_SAR) begin
            if (!comp_s) trial[bit_idx] = 1'b0;
            if (bit_idx == '0) begin
              fin = 1'b1;
              res = trial;
            end else begin
              trial[bit_idx - 1'b1] = 1'b1;
              idx_nxt   = bit_idx - 1'b1;
              code_nxt  = trial;
              state_nxt = SETTLE;
            end
          end else begin
            if (!comp_s) begin
              fin = 1'b1;
              res = (dac_code == '0) ? '0 : dac_code - 1'b1;
            end else if (dac_code == CODE_MAX) begin
              fin = 1'b1;
              res = CODE_MAX;
            end else begin
              code_nxt  = dac_code + 1'b1;
              state_nxt = SETTLE;
            end
          end

          if (fin) begin
            code_nxt  = res;
            adc_nxt   = ADC_OUT_W'(res) << (ADC_OUT_W - WIDTH);
            ready_nxt = 1'b1;
            state_nxt = DONE;
          end
        end

        DONE: state_nxt = WAIT_TICK;

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
